// File: rtl/mem_arbiter.sv
// Arbitrates the shared RAM port between instruction fetch and data access.
// Data wins by default; a completion-streak counter bounds fetch starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              iREN,
  input  logic [31:0]                       iaddr,
  output logic                              iwait,
  output logic [31:0]                       iload,
  input  logic                              dREN,
  input  logic                              dWEN,
  input  logic [31:0]                       daddr,
  input  logic [31:0]                       dstore,
  output logic                              dwait,
  output logic [31:0]                       dload,
  output logic                              ramREN,
  output logic                              ramWEN,
  output logic [31:0]                       ramaddr,
  output logic [31:0]                       ramstore,
  input  logic [31:0]                       ramload,
  input  logic [1:0]                        ramstate,
  output logic [1:0]                        state_dbg,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] streak_dbg
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, ISERVE = 2'd1, DSERVE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q;
  logic          d_req;
  logic          starve;
  logic          i_done;
  logic          d_done;

  // Handshake: a requester raises its enable and holds it until its wait
  // output is 0 in a cycle; that cycle is the completion and carries load.
  assign d_req  = dREN | dWEN;
  assign starve = iREN && (streak_q == SW'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !starve)  state_d = DSERVE;
        else if (iREN)         state_d = ISERVE;
        else if (d_req)        state_d = DSERVE;
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          i_done  = 1'b1;
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          state_d = IDLE;
        end
      end
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Streak counts data completions that happened while a fetch was waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
    end else if (d_done && iREN) begin
      if (streak_q != SW'(STARVE_LIMIT)) streak_q <= streak_q + 1'b1;
    end else if (i_done || !iREN) begin
      streak_q <= '0;
    end
  end

  assign iwait      = iREN & ~i_done;
  assign dwait      = d_req & ~d_done;
  assign iload      = i_done ? ramload : '0;
  assign dload      = d_done ? ramload : '0;
  assign state_dbg  = state_q;
  assign streak_dbg = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are checked by a monitor
// against an expected queue of {side, load data}; side 1 = data, 0 = fetch.
module tb_mem_arbiter;

  localparam int W = 33;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISERVE = 2'd1, S_DSERVE = 2'd2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  state_dbg;
  logic [2:0]  streak_dbg;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .state_dbg(state_dbg), .streak_dbg(streak_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  task automatic pop_cmp(input logic side, input logic [31:0] data);
    logic [W-1:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_completion: got side=%0d data=%h expected none", side, data);
    end else begin
      e = exp_q.pop_front();
      if ({side, data} !== e) begin
        miscompares++;
        $display("FAIL completion: got side=%0d data=%h expected side=%0d data=%h",
                 side, data, e[32], e[31:0]);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (iREN && !iwait) pop_cmp(1'b0, iload);
      if ((dREN | dWEN) && !dwait) pop_cmp(1'b1, dload);
    end
  end

  // driver helpers: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // reset with a fetch pending
    sample();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_iload", iload, 0);
    step();
    nRST = 1'b1;

    // fetch: IDLE, BUSY, BUSY, ACCESS
    exp_q.push_back({1'b0, 32'h8C220004});
    sample();
    chk("if_wait1", iwait, 1);
    step(); ramstate = BUSY;
    sample();
    chk("if_state", state_dbg, S_ISERVE);
    chk("if_ramaddr", ramaddr, 32'h40);
    chk("if_ramREN", ramREN, 1);
    chk("if_wait2", iwait, 1);
    step();
    sample();
    chk("if_wait3", iwait, 1);
    step(); ramstate = ACCESS; ramload = 32'h8C220004;
    sample();
    chk("if_done_wait", iwait, 0);
    step(); iREN = 1'b0; ramstate = FREE;
    sample();
    chk("if_after_state", state_dbg, S_IDLE);
    chk("if_after_iload", iload, 0);

    // contention: data write first, fetch after one IDLE cycle
    step();
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ramstate = ACCESS; ramload = 32'h11111111;
    exp_q.push_back({1'b1, 32'h11111111});
    exp_q.push_back({1'b0, 32'h22222222});
    sample();
    chk("ct_idle_iwait", iwait, 1);
    chk("ct_idle_dwait", dwait, 1);
    step();
    sample();
    chk("ct_d_state", state_dbg, S_DSERVE);
    chk("ct_ramWEN", ramWEN, 1);
    chk("ct_ramREN", ramREN, 0);
    chk("ct_ramaddr", ramaddr, 32'h100);
    chk("ct_ramstore", ramstore, 32'hDEADBEEF);
    step(); dWEN = 1'b0; ramload = 32'h22222222;
    sample();
    chk("ct_gap_state", state_dbg, S_IDLE);
    chk("ct_gap_streak", streak_dbg, 1);
    step();
    sample();
    chk("ct_i_state", state_dbg, S_ISERVE);
    chk("ct_i_ramaddr", ramaddr, 32'h80);
    step(); iREN = 1'b0;

    // starvation: 4 data completions then 1 fetch, twice
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
    ramstate = ACCESS; ramload = 32'h5A5A0000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 32'h5A5A0000});
      exp_q.push_back({1'b0, 32'h5A5A0000});
    end
    for (int c = 1; c <= 20; c++) begin
      sample();
      if (c == 9) begin
        chk("sv_streak_full", streak_dbg, 4);
        chk("sv_idle", state_dbg, S_IDLE);
      end
      if (c == 10) chk("sv_i_grant", state_dbg, S_ISERVE);
      if (c == 11) chk("sv_streak_clr", streak_dbg, 0);
      if (c == 18) chk("sv_d_grant2", state_dbg, S_DSERVE);
      step();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    sample();
    chk("sv_end_state", state_dbg, S_IDLE);

    // ERROR in DSERVE, then re-grant
    step(); dREN = 1'b1; daddr = 32'h44; ramstate = ERROR;
    sample();
    step();
    sample();
    chk("er_state", state_dbg, S_DSERVE);
    chk("er_dwait", dwait, 1);
    step(); ramstate = ACCESS; ramload = 32'h33333333;
    exp_q.push_back({1'b1, 32'h33333333});
    sample();
    chk("er_back_idle", state_dbg, S_IDLE);
    chk("er_dwait_idle", dwait, 1);
    step();
    sample();
    chk("er_regrant", state_dbg, S_DSERVE);
    step(); dREN = 1'b0; ramstate = FREE;

    // abort: drop dREN while BUSY
    dREN = 1'b1; daddr = 32'h48; ramstate = BUSY;
    sample();
    step();
    sample();
    chk("ab_ramREN_on", ramREN, 1);
    step(); dREN = 1'b0;
    sample();
    chk("ab_ramREN_off", ramREN, 0);
    chk("ab_dwait", dwait, 0);
    step();
    sample();
    chk("ab_idle", state_dbg, S_IDLE);

    // reset mid-DSERVE with a write in flight and a nonzero streak
    step();
    iREN = 1'b1; iaddr = 32'h90; dWEN = 1'b1; daddr = 32'h104; dstore = 32'hCAFEF00D;
    ramstate = ACCESS; ramload = 32'h44444444;
    exp_q.push_back({1'b1, 32'h44444444});
    sample();
    step();
    sample();
    step(); ramstate = BUSY;
    sample();
    step();
    sample();
    chk("rm_state", state_dbg, S_DSERVE);
    chk("rm_ramWEN_on", ramWEN, 1);
    chk("rm_streak", streak_dbg, 1);
    #2 nRST = 1'b0;
    #1;
    chk("rm_ramWEN_async", ramWEN, 0);
    chk("rm_state_async", state_dbg, S_IDLE);
    step();
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    nRST = 1'b1;
    sample();
    chk("rm_streak_clr", streak_dbg, 0);
    step();
    sample();

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single shared RAM port between the instruction-fetch and data requesters of the CPU. It sits between the request unit's memory enables (iREN, dREN/dWEN) and the RAM: it grants one requester at a time, drives the RAM port from the winner, and returns per-side wait signals. Data accesses have priority, and a streak counter bounds instruction-fetch starvation.

## Interface
- STARVE_LIMIT, 4, max consecutive data completions allowed while an instruction fetch is pending (≥1)
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request, held until iwait=0
- iaddr  in  32  instruction word address
- iwait  out  1  1 = instruction request not yet complete
- iload  out  32  instruction data, valid when iREN=1 and iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request (wins if dREN also high)
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  1 = data request not yet complete
- dload  out  32  data read value, valid when dREN=1 and dwait=0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write value
- ramload  in  32  RAM read value
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (cpu_types_pkg ramstate_t)

## Operation
- FSM states: IDLE, ISERVE, DSERVE. Reset → IDLE, streak=0.
- IDLE: RAM outputs all 0. Arbitration, evaluated in this order:
  - (dREN|dWEN) and not starve → DSERVE
  - iREN → ISERVE
  - (dREN|dWEN) → DSERVE
  - otherwise stay in IDLE.
  - starve = iREN && streak==STARVE_LIMIT.
- DSERVE: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
- ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Serve state, ramstate==ACCESS: the granted side completes this cycle.
  - Its wait=0; load output = ramload.
  - Next state IDLE.
- Serve state, ramstate FREE or BUSY: stay in the state; wait=1.
- Serve state, ramstate==ERROR: no completion; go to IDLE and re-arbitrate; wait stays 1.
- Granted requester drops its enable before ACCESS: go to IDLE next cycle, with no completion. RAM enables follow the enable combinationally, so they deassert in the same cycle.
- Wait outputs:
  - iwait = iREN & ~(ISERVE & ACCESS)
  - dwait = (dREN|dWEN) & ~(DSERVE & ACCESS)
  - A side that is not requesting sees wait=0.
- iload/dload = ramload when their side completes, else 0.
- Streak counter, width $clog2(STARVE_LIMIT+1), saturating:
  - data completion with iREN=1 → +1
  - instruction completion, or iREN=0 → 0
  - otherwise hold.
- Only the granted side's RAM outputs are ever driven; no two-way overlap is possible.

## Timing
- Outputs during reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, iwait=iREN, dwait=dREN|dWEN.
- Arbitration is registered. A request seen in IDLE at edge k drives the RAM from cycle k+1. Minimum latency is 2 cycles (wait low in the 2nd cycle of the request).
- After a completion, one IDLE cycle always follows before the next grant. Throughput is at most 1 access per 2 cycles plus RAM latency.
- Simultaneous i and d requests in IDLE: data wins unless starve=1.
- nRST low mid-transaction: immediately IDLE, with RAM enables 0 asynchronously. The transaction is lost; the requester re-issues it after reset.
- A completion and a new request from the same side in the same cycle: the new request is arbitrated in the following IDLE cycle.

## Test plan
- Reset: nRST=0 with iREN=1 → ramREN=0, iwait=1, state IDLE. Release; next edge → ISERVE, ramaddr=iaddr.
- Instruction fetch, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004:
  - iwait=1 for 3 cycles.
  - Then iwait=0 and iload=0x8C220004 for exactly 1 cycle.
- Contention, iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) arriving together:
  - The data write is served first: ramWEN=1 with the write value.
  - The fetch is granted after the next IDLE cycle.
- Starvation, STARVE_LIMIT=4, dREN held high and iREN=1, RAM always ACCESS:
  - Exactly 4 data completions, then 1 instruction completion.
  - streak returns to 0; the pattern repeats.
- ERROR and abort:
  - ramstate=ERROR in DSERVE → dwait stays 1, FSM returns to IDLE, then re-grants data.
  - dREN dropped during BUSY → ramREN=0 in the same cycle, IDLE next cycle.
- Reset mid-DSERVE with ramWEN=1 → ramWEN=0 without waiting for a clock edge; after release, streak=0.
